// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing constants, pattern-mode enum and sync-phase helper
package vga_pkg;
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int RGB_W      = 6;

    typedef enum logic [1:0] {PAT_BARS, PAT_CHECKER, PAT_GRAD, PAT_SOLID} pat_mode_e;
    typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_e;

    function automatic phase_e phase_of(input int cnt, input int act, input int fp, input int sync);
        return cnt < act ? PH_ACT : cnt < act + fp ? PH_FP : cnt < act + fp + sync ? PH_SYNC : PH_BP;
    endfunction
endpackage

// File: rtl/vga_pattern.sv
// vga_pattern: frame-synchronous test-pattern engine (bar counter, mode/invert shadows, rgb register)
module vga_pattern
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int CW       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             h_end,
    input  logic             de_nx,
    input  logic             load,
    input  logic [CW-1:0]    x,
    input  logic [CW-1:0]    y,
    input  logic [1:0]       mode,
    input  logic             invert,
    output logic [RGB_W-1:0] rgb
);
    localparam int BW = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
    localparam int PW = $clog2(BW) + 1;

    logic [PW-1:0] bar_pix;
    logic [2:0]    bar_idx;
    pat_mode_e     mode_q, mode_e;
    logic          invert_q, invert_e;
    logic [2:0]    xs, ys;
    logic [5:0]    pat;

    // At the frame origin the live inputs are used so a coincident change lands in this frame
    assign mode_e   = load ? pat_mode_e'(mode) : mode_q;
    assign invert_e = load ? invert : invert_q;
    assign xs       = 3'(x >> 5);
    assign ys       = 3'(y >> 5);
    assign pat = mode_e == PAT_BARS    ? {{2{bar_idx[2]}}, {2{bar_idx[1]}}, {2{bar_idx[0]}}}
               : mode_e == PAT_CHECKER ? {6{xs[0] ^ ys[0]}}
               : mode_e == PAT_GRAD    ? {xs[2:1], ys[2:1], xs[2:1] ^ ys[2:1]}
               : 6'h3F;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_pix  <= '0;
            bar_idx  <= '0;
            mode_q   <= PAT_BARS;
            invert_q <= 1'b0;
            rgb      <= '0;
        end else if (!en) begin
            bar_pix <= '0;
            bar_idx <= '0;
            rgb     <= '0;
        end else begin
            mode_q   <= mode_e;
            invert_q <= invert_e;
            rgb      <= de_nx ? pat ^ {6{invert_e}} : '0;
            // Last bar absorbs any remainder: the index saturates at 7
            if (h_end) begin
                bar_pix <= '0;
                bar_idx <= '0;
            end else if (bar_pix == PW'(BW - 1) && bar_idx != 3'd7) begin
                bar_pix <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else if (bar_pix != PW'(BW - 1)) begin
                bar_pix <= bar_pix + PW'(1);
            end
        end
    end
endmodule

// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen: parametrised VGA sync/de timing with optional test-pattern engine.
// Define VGA_PATTERN_EN to compile in the pattern engine; otherwise rgb is tied to zero.
module vga_timing_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_D,
    parameter int H_FP      = H_FP_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BP      = H_BP_D,
    parameter int V_ACTIVE  = V_ACTIVE_D,
    parameter int V_FP      = V_FP_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BP      = V_BP_D,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             invert,
    output logic [CW-1:0]    x,
    output logic [CW-1:0]    y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start,
    output logic [RGB_W-1:0] rgb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CW-1:0] h_cnt, v_cnt;
    phase_e        h_ph, v_ph;
    logic          h_end, v_end, de_nx, at_origin;

    assign x         = h_cnt;
    assign y         = v_cnt;
    assign h_ph      = phase_of(int'(h_cnt), H_ACTIVE, H_FP, H_SYNC);
    assign v_ph      = phase_of(int'(v_cnt), V_ACTIVE, V_FP, V_SYNC);
    assign h_end     = h_cnt == CW'(H_TOTAL - 1);
    assign v_end     = v_cnt == CW'(V_TOTAL - 1);
    assign de_nx     = h_ph == PH_ACT && v_ph == PH_ACT;
    assign at_origin = h_cnt == '0 && v_cnt == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= !HSYNC_POL;
            vsync       <= !VSYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= !HSYNC_POL;
            vsync       <= !VSYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_end ? '0 : h_cnt + CW'(1);
            v_cnt       <= !h_end ? v_cnt : v_end ? '0 : v_cnt + CW'(1);
            hsync       <= h_ph == PH_SYNC ? HSYNC_POL : !HSYNC_POL;
            vsync       <= v_ph == PH_SYNC ? VSYNC_POL : !VSYNC_POL;
            de          <= de_nx;
            frame_start <= at_origin;
        end
    end

`ifdef VGA_PATTERN_EN
    vga_pattern #(.H_ACTIVE(H_ACTIVE), .CW(CW)) u_pattern (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .h_end  (h_end),
        .de_nx  (de_nx),
        .load   (at_origin),
        .x      (h_cnt),
        .y      (v_cnt),
        .mode   (mode),
        .invert (invert),
        .rgb    (rgb)
    );
`else
    logic unused_pattern;
    assign unused_pattern = ^{mode, invert};
    assign rgb = '0;
`endif
endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// tb_vga_timing_pattern_gen: frame-position model of a 24x12 raster checked every cycle, plus literal pins
module tb_vga_timing_pattern_gen;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
`ifdef VGA_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, en = 1'b1, invert = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] x0, y0, x1, y1;
    logic hs0, vs0, de0, fs0, hs1, vs1, de1, fs1;
    logic [5:0] rgb0, rgb1;

    int vectors = 0, miscompares = 0;
    int pos;
    logic e_hs, e_vs, e_de, e_fs;
    logic [5:0] e_rgb;
    logic [1:0] m_mode;
    logic m_inv;
    logic [5:0] bars [0:23] = '{6'h00, 6'h00, 6'h03, 6'h03, 6'h0C, 6'h0C, 6'h0F, 6'h0F,
                                6'h30, 6'h30, 6'h33, 6'h33, 6'h3C, 6'h3C, 6'h3F, 6'h3F,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    always #5 clk = ~clk;

    vga_timing_pattern_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(10)) d0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .invert(invert), .x(x0), .y(y0),
        .hsync(hs0), .vsync(vs0), .de(de0), .frame_start(fs0), .rgb(rgb0));

    vga_timing_pattern_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(10)) d1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .invert(invert), .x(x1), .y(y1),
        .hsync(hs1), .vsync(vs1), .de(de1), .frame_start(fs1), .rgb(rgb1));

    task automatic lit(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] pat_exp(input int h, input int v, input logic [1:0] m);
        logic [2:0] i;
        logic [7:0] hb, vb;
        hb = 8'(h);
        vb = 8'(v);
        i = 3'((h / (HA / 8)) > 7 ? 7 : h / (HA / 8));
        case (m)
            2'd0: return {i[2], i[2], i[1], i[1], i[0], i[0]};
            2'd1: return (hb[5] ^ vb[5]) ? 6'h3F : 6'h00;
            2'd2: return {hb[7:6], vb[7:6], hb[7:6] ^ vb[7:6]};
            default: return 6'h3F;
        endcase
    endfunction

    task automatic model_idle();
        pos = 0;
        e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_fs = 1'b0; e_rgb = 6'h00;
    endtask

    task automatic model_reset();
        model_idle();
        m_mode = 2'd0;
        m_inv = 1'b0;
    endtask

    // Outputs seen after an edge describe the raster position held before it
    task automatic model_step();
        int h, v;
        if (rst) model_reset();
        else if (!en) model_idle();
        else begin
            h = pos % HT;
            v = pos / HT;
            if (pos == 0) begin
                m_mode = mode;
                m_inv = invert;
            end
            e_hs = h >= HA + HF && h < HA + HF + HS;
            e_vs = v >= VA + VF && v < VA + VF + VS;
            e_de = h < HA && v < VA;
            e_fs = pos == 0;
            e_rgb = (PAT && e_de) ? pat_exp(h, v, m_mode) ^ {6{m_inv}} : 6'h00;
            pos = (pos + 1) % FRAME;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        lit("x0", int'(x0), pos % HT);
        lit("y0", int'(y0), pos / HT);
        lit("hsync0", int'(hs0), int'(!e_hs));
        lit("vsync0", int'(vs0), int'(!e_vs));
        lit("de0", int'(de0), int'(e_de));
        lit("frame_start0", int'(fs0), int'(e_fs));
        lit("rgb0", int'(rgb0), int'(e_rgb));
        lit("x1", int'(x1), pos % HT);
        lit("hsync1", int'(hs1), int'(e_hs));
        lit("vsync1", int'(vs1), int'(!e_vs));
        lit("de1", int'(de1), int'(e_de));
        lit("rgb1", int'(rgb1), int'(e_rgb));
    end

    task automatic wait_fs(input string nm);
        int n = 0;
        do begin tick(); n++; end while (!fs0 && n < 400);
        if (!fs0) lit({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_xy(input int tx, input int ty, input string nm);
        int n = 0;
        while (!(int'(x0) == tx && int'(y0) == ty) && n < 400) begin tick(); n++; end
        if (n >= 400) lit({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int per, nhs, nvs, nsolid, nhs1;
        model_reset();
        repeat (2) tick();
        lit("rst_hsync", int'(hs0), 1);
        lit("rst_hsync_pol1", int'(hs1), 0);
        lit("rst_de", int'(de0), 0);
        lit("rst_rgb", int'(rgb0), 0);
        rst = 1'b0;
        tick();
        lit("fs_after_rst", int'(fs0), 1);
        per = 0; nhs = 0; nvs = 0;
        do begin
            if (per < 24) lit("bars_line0", int'(rgb0), PAT ? int'(bars[per]) : 0);
            if (!hs0) nhs++;
            if (!vs0) nvs++;
            tick();
            per++;
        end while (!fs0 && per < 400);
        lit("frame_period", per, FRAME);
        lit("hsync_low_cycles", nhs, VT * HS);
        lit("vsync_low_cycles", nvs, HT * VS);

        wait_xy(0, 3, "inv_line3");
        invert = 1'b1;
        wait_fs("inv_fs");
        lit("inv_first_pixel", int'(rgb0), PAT ? 'h3F : 0);
        per = 0;
        while (de0 && per < 40) begin tick(); per++; end
        lit("inv_blank_rgb", int'(rgb0), 0);

        mode = 2'd3;
        invert = 1'b0;
        wait_fs("solid_fs");
        nsolid = 0; nhs1 = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (rgb1 == 6'h3F) nsolid++;
            if (hs1) nhs1++;
            tick();
        end
        lit("solid_pixels", nsolid, PAT ? HA * VA : 0);
        lit("hsync_pol1_high", nhs1, VT * HS);
        lit("solid_next_fs", int'(fs0), 1);

        mode = 2'd1;
        wait_fs("checker_a"); wait_fs("checker_b");
        mode = 2'd2;
        wait_fs("grad_a"); wait_fs("grad_b");
        mode = 2'd3;
        wait_fs("solid2");

        wait_xy(10, 4, "rst_point");
        lit("pre_rst_de", int'(de0), 1);
        rst = 1'b1;
        model_reset();
        #1;
        lit("mid_rst_x", int'(x0), 0);
        lit("mid_rst_y", int'(y0), 0);
        lit("mid_rst_de", int'(de0), 0);
        lit("mid_rst_rgb", int'(rgb0), 0);
        lit("mid_rst_hsync", int'(hs0), 1);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        lit("fs_after_mid_rst", int'(fs0), 1);
        lit("x_after_mid_rst", int'(x0), 1);

        wait_xy(5, 2, "en_point");
        en = 1'b0;
        tick();
        lit("en_low_de", int'(de0), 0);
        lit("en_low_rgb", int'(rgb0), 0);
        lit("en_low_hsync", int'(hs0), 1);
        lit("en_low_vsync", int'(vs0), 1);
        repeat (49) tick();
        lit("en_low_x", int'(x0), 0);
        lit("en_low_y", int'(y0), 0);
        en = 1'b1;
        tick();
        lit("fs_after_en", int'(fs0), 1);
        lit("rgb_after_en", int'(rgb0), PAT ? 'h3F : 0);
        wait_fs("final");
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
